// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV M-extension multiply/divide unit
//
// Purpose:
//   Executes the eight RV M-extension ops (funct3 encoded) in several cycles.
//   Multiplies complete a fixed MUL_LAT edges after accept.
//   Divides use a restoring shift-subtract loop that yields one quotient bit
//   per edge, followed by a sign fix-up edge.
//   Divide-by-zero and signed overflow resolve on the first edge after accept.
//
// Optional feature (macro MULDIV_DIV_EARLY_EN):
//   When defined, a divide whose dividend magnitude is below a nonzero divisor
//   magnitude also resolves on the first edge (quotient 0, remainder rs1).
//   Results are identical with or without the macro; only latency differs.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   enabled    in   start request, sampled only while busy=0
//   op         in   funct3: 0 mul 1 mulh 2 mulhsu 3 mulhu 4 div 5 divu 6 rem 7 remu
//   rs1, rs2   in   operands
//   kill       in   abort the in-flight op, no completion, result held
//   busy       out  op in flight
//   completed  out  one-cycle pulse, result valid in that cycle
//   result     out  result, held until the next completion

module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enabled,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] result
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;      // op[2] is implied by which state we are in
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;     // holds the dividend magnitude, shifted out MSB first
  logic [XLEN-1:0] dvs_q;     // divisor magnitude
  logic            q_neg_q;
  logic            r_neg_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  assign busy      = busy_q;
  assign completed = done_q;
  assign result    = result_q;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept: magnitudes and signs for the divider
  // ---------------------------------------------------------------------------
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;

  always_comb begin
    rs1_neg = ~op[0] & rs1[XLEN-1];
    rs2_neg = ~op[0] & rs2[XLEN-1];
    rs1_abs = rs1_neg ? -rs1 : rs1;
    rs2_abs = rs2_neg ? -rs2 : rs2;
  end

  // ---------------------------------------------------------------------------
  // Multiplier: sign-extend both operands to 2*XLEN; the low 2*XLEN bits of the
  // unsigned product then equal the signed/mixed product modulo 2^(2*XLEN).
  // ---------------------------------------------------------------------------
  logic            mul_a_sx;
  logic            mul_b_sx;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    mul_a_sx  = (op_q != 2'b11) & a_q[XLEN-1];  // signed rs1 for mul/mulh/mulhsu
    mul_b_sx  = ~op_q[1] & b_q[XLEN-1];         // signed rs2 for mul/mulh only
    mul_a_ext = {{XLEN{mul_a_sx}}, a_q};
    mul_b_ext = {{XLEN{mul_b_sx}}, b_q};
    prod      = mul_a_ext * mul_b_ext;
    mul_res   = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------------
  // Restoring divide step. The partial remainder is always below the divisor,
  // so the XLEN+1 bit difference borrows exactly when part < divisor.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   part;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  always_comb begin
    part     = {rem_q, quo_q[XLEN-1]};
    diff     = part - {1'b0, dvs_q};
    ge       = ~diff[XLEN];
    rem_step = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
  end

  // ---------------------------------------------------------------------------
  // Special divide cases, evaluated on the first edge after accept
  // ---------------------------------------------------------------------------
  logic            div_zero;
  logic            div_ovf;
  logic            div_early;
  logic            div_special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    div_zero = (b_q == '0);
    div_ovf  = ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (&b_q);
`ifdef MULDIV_DIV_EARLY_EN
    // quo_q still holds the unshifted dividend magnitude on the first edge
    div_early = ~div_zero & (quo_q < dvs_q);
`else
    div_early = 1'b0;
`endif
    div_special = div_zero | div_ovf | div_early;
    if (div_zero) begin
      special_res = op_q[1] ? a_q : '1;
    end else if (div_ovf) begin
      special_res = op_q[1] ? '0 : a_q;
    end else begin
      special_res = op_q[1] ? a_q : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up of the unsigned quotient/remainder
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] fix_res;

  always_comb begin
    if (op_q[1]) begin
      fix_res = r_neg_q ? -rem_q : rem_q;
    end else begin
      fix_res = q_neg_q ? -quo_q : quo_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Completion decode
  // ---------------------------------------------------------------------------
  logic            fin_d;
  logic [XLEN-1:0] fin_val_d;

  always_comb begin
    fin_d     = 1'b0;
    fin_val_d = mul_res;
    case (state_q)
      S_MUL: begin
        fin_d     = (cnt_q == CW'(MUL_LAT));
        fin_val_d = mul_res;
      end
      S_DIV: begin
        fin_d     = (cnt_q == CW'(1)) & div_special;
        fin_val_d = special_res;
      end
      S_FIX: begin
        fin_d     = 1'b1;
        fin_val_d = fix_res;
      end
      default: begin
        fin_d     = 1'b0;
        fin_val_d = mul_res;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        // Flush wins over accept and over completion in the same edge
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enabled) begin
              op_q    <= op[1:0];
              a_q     <= rs1;
              b_q     <= rs2;
              quo_q   <= rs1_abs;
              dvs_q   <= rs2_abs;
              rem_q   <= '0;
              q_neg_q <= rs1_neg ^ rs2_neg;
              r_neg_q <= rs1_neg;
              cnt_q   <= CW'(1);
              busy_q  <= 1'b1;
              state_q <= op[2] ? S_DIV : S_MUL;
            end
          end
          S_MUL: begin
            if (fin_d) begin
              result_q <= fin_val_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_DIV: begin
            if (fin_d) begin
              result_q <= fin_val_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              cnt_q    <= '0;
              state_q  <= S_IDLE;
            end else begin
              rem_q <= rem_step;
              quo_q <= quo_step;
              if (cnt_q == CW'(XLEN)) begin
                cnt_q   <= '0;
                state_q <= S_FIX;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          S_FIX: begin
            result_q <= fin_val_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
